conv_z_streamer: RTL and testbench

- Downstream stage of the 8x32 convolution coprocessor.
- On start, it reads the finished Z result vector (length sizeX+sizeY-1) from the 16-bit result RAM through that RAM's synchronous read port.
- It streams the words out over a valid/ready interface.
- A small internal FIFO absorbs sink backpressure while keeping one word per cycle throughput.
- start_i is normally driven by the coprocessor's done pulse.

---
 rtl/conv_z_streamer.sv | 143 ++++++++++++++
 tb/tb_conv_z_streamer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_z_streamer.sv
// Streams the convolution Z result vector out of the result RAM over valid/ready.
// Reads are credit-limited so the small output FIFO can never overflow.
module conv_z_streamer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6,
    parameter int SIZE_WIDTH = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [SIZE_WIDTH-1:0] sizeX,
    input  logic [SIZE_WIDTH-1:0] sizeY,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  m_last_o,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   n_q;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic                    v1_q, l1_q, v2_q, l2_q;
    logic [DATA_WIDTH-1:0]   fifo_data_q [FIFO_DEPTH];
    logic                    fifo_last_q [FIFO_DEPTH];
    logic [PW-1:0]           wr_idx_q, rd_idx_q;
    logic [CW-1:0]           count_q;
    logic                    busy_q, done_q;

    logic [ADDR_WIDTH-1:0]   n_start_d;
    logic [ADDR_WIDTH-1:0]   n_last_d;
    logic [CW-1:0]           used_d;
    logic                    push_d, pop_d, credit_d, drained_d;

    always_comb begin
        n_start_d = '0;
        if (sizeX != '0 && sizeY != '0)
            n_start_d = ADDR_WIDTH'(sizeX) + ADDR_WIDTH'(sizeY) - ADDR_WIDTH'(1);
        n_last_d = n_q - ADDR_WIDTH'(1);
        push_d   = v2_q;
        pop_d    = (count_q != '0) && m_ready_i;
        // Credit counts FIFO entries plus reads still travelling through the RAM pipe.
        used_d   = count_q + CW'(v1_q) + CW'(v2_q);
        credit_d = used_d < CW'(FIFO_DEPTH);
        drained_d = !v1_q && !v2_q &&
                    ((count_q == '0) || (count_q == CW'(1) && pop_d));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            n_q        <= '0;
            rd_ptr_q   <= '0;
            mem_addr_q <= '0;
            v1_q       <= 1'b0;
            l1_q       <= 1'b0;
            v2_q       <= 1'b0;
            l2_q       <= 1'b0;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            done_q <= 1'b0;
            v1_q   <= 1'b0;
            l1_q   <= 1'b0;
            v2_q   <= v1_q;
            l2_q   <= l1_q;

            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        busy_q <= 1'b1;
                        if (n_start_d != '0) begin
                            n_q        <= n_start_d;
                            mem_addr_q <= '0;
                            v1_q       <= 1'b1;
                            l1_q       <= (n_start_d == ADDR_WIDTH'(1));
                            rd_ptr_q   <= ADDR_WIDTH'(1);
                            state_q    <= (n_start_d == ADDR_WIDTH'(1)) ? DRAIN : RUN;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end
                    end
                end
                RUN: begin
                    if (credit_d) begin
                        mem_addr_q <= rd_ptr_q;
                        v1_q       <= 1'b1;
                        l1_q       <= (rd_ptr_q == n_last_d);
                        rd_ptr_q   <= rd_ptr_q + ADDR_WIDTH'(1);
                        if (rd_ptr_q == n_last_d)
                            state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drained_d) begin
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            if (push_d) begin
                fifo_data_q[wr_idx_q] <= mem_rd_data_i;
                fifo_last_q[wr_idx_q] <= l2_q;
                wr_idx_q              <= wr_idx_q + PW'(1);
            end
            if (pop_d)
                rd_idx_q <= rd_idx_q + PW'(1);
            count_q <= count_q + CW'(push_d) - CW'(pop_d);
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(push_d && count_q == CW'(FIFO_DEPTH)));

    assign mem_addr_o = mem_addr_q;
    assign m_data_o   = fifo_data_q[rd_idx_q];
    assign m_last_o   = fifo_last_q[rd_idx_q];
    assign m_valid_o  = (count_q != '0);
    assign busy_o     = busy_q;
    assign done_o     = done_q;
endmodule

// File: tb/tb_conv_z_streamer.sv
// Scoreboard bench for conv_z_streamer: stimulus queues expected beats, a
// negedge monitor pops and compares on every handshake.
module tb_conv_z_streamer;
    localparam int DW = 16;
    localparam int AW = 6;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [SW-1:0] sizeX, sizeY;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_rd_data_i;
    logic [DW-1:0] m_data_o;
    logic          m_valid_o, m_ready_i, m_last_o, busy_o, done_o;

    logic [DW-1:0] ram [64];

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   beats = 0;
    int   done_cnt = 0;

    conv_z_streamer #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .SIZE_WIDTH(SW),
        .FIFO_DEPTH(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .sizeX        (sizeX),
        .sizeY        (sizeY),
        .mem_addr_o   (mem_addr_o),
        .mem_rd_data_i(mem_rd_data_i),
        .m_data_o     (m_data_o),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .m_last_o     (m_last_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_rd_data_i <= ram[mem_addr_o];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Inputs only change #1 after posedge, so a negedge sample predicts the next edge exactly.
    logic          pv = 1'b0, pr = 1'b0, plast = 1'b0;
    logic [DW-1:0] pd = '0;
    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("hold_valid", 32'(m_valid_o), 32'd1);
                chk("hold_data", 32'(m_data_o), 32'(pd));
                chk("hold_last", 32'(m_last_o), 32'(plast));
            end
            if (done_o) done_cnt++;
            if (m_valid_o && m_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h expected no beat", m_data_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", 32'(m_data_o), 32'(e.d));
                    chk("beat_last", 32'(m_last_o), 32'(e.l));
                end
                beats++;
            end
            pv = m_valid_o;
            pr = m_ready_i;
            pd = m_data_o;
            plast = m_last_o;
        end
    end

    // mode: 0 full rate, 1 backpressure, 2 extra start mid-stream, 3 reset mid-stream
    task automatic run_stream(input int sx, input int sy, input int mode);
        int            n, cyc, stall;
        bit            fired, aborted;
        logic [AW-1:0] a0;
        n = (sx == 0 || sy == 0) ? 0 : sx + sy - 1;
        for (int i = 0; i < n; i++) exp_q.push_back({ram[i], (i == n - 1)});
        beats = 0;
        done_cnt = 0;
        stall = 0;
        fired = 0;
        aborted = 0;
        @(posedge clk); #1;
        sizeX = SW'(sx);
        sizeY = SW'(sy);
        start_i = 1'b1;
        m_ready_i = 1'b1;
        a0 = mem_addr_o;
        @(posedge clk); #1;
        start_i = 1'b0;
        sizeX = SW'($urandom_range(31));
        sizeY = SW'($urandom_range(31));
        chk("busy_after_start", 32'(busy_o), 32'd1);
        chk("valid_e0", 32'(m_valid_o), 32'd0);
        if (n == 0) begin
            chk("zero_done", 32'(done_o), 32'd1);
            chk("zero_addr", 32'(mem_addr_o), 32'(a0));
            @(posedge clk); #1;
            chk("zero_busy_drop", 32'(busy_o), 32'd0);
            chk("zero_done_drop", 32'(done_o), 32'd0);
            chk("zero_valid", 32'(m_valid_o), 32'd0);
            chk("zero_addr2", 32'(mem_addr_o), 32'(a0));
            @(posedge clk); #1;
            chk("zero_done_count", 32'(done_cnt), 32'd1);
            chk("zero_no_beats", 32'(beats), 32'd0);
            return;
        end
        chk("first_addr", 32'(mem_addr_o), 32'd0);
        cyc = 0;
        while (!done_o && cyc < 400 && !aborted) begin
            if (cyc == 1) chk("lat_e1_valid", 32'(m_valid_o), 32'd0);
            if (cyc == 2 && mode != 3) chk("lat_e2_valid", 32'(m_valid_o), 32'd1);
            if (cyc == 2 && mode != 3) chk("lat_e2_word0", 32'(m_data_o), 32'(ram[0]));
            case (mode)
                1: begin
                    if (beats >= 3 && stall < 3) begin
                        m_ready_i = 1'b0;
                        stall++;
                    end else if (stall >= 3) begin
                        m_ready_i = ~m_ready_i;
                    end
                end
                2: begin
                    start_i = (beats == 5 && !fired);
                    if (beats == 5) fired = 1;
                end
                3: begin
                    if (beats >= 6) begin
                        m_ready_i = 1'b0;
                        stall++;
                        if (stall == 4) begin
                            rst = 1'b1;
                            exp_q.delete();
                            aborted = 1;
                        end
                    end
                end
                default: ;
            endcase
            @(posedge clk); #1;
            cyc++;
        end
        start_i = 1'b0;
        if (aborted) begin
            rst = 1'b0;
            chk("rst_valid", 32'(m_valid_o), 32'd0);
            chk("rst_data", 32'(m_data_o), 32'd0);
            chk("rst_last", 32'(m_last_o), 32'd0);
            chk("rst_busy", 32'(busy_o), 32'd0);
            chk("rst_done", 32'(done_o), 32'd0);
            chk("rst_addr", 32'(mem_addr_o), 32'd0);
            m_ready_i = 1'b1;
            repeat (6) @(posedge clk);
            #1;
            chk("rst_no_done", 32'(done_cnt), 32'd0);
            chk("rst_still_idle", 32'(m_valid_o), 32'd0);
            return;
        end
        chk("done_seen", 32'(done_o), 32'd1);
        chk("busy_at_done", 32'(busy_o), 32'd1);
        if (mode == 0) chk("done_latency", 32'(cyc), 32'(n + 2));
        chk("beat_count", 32'(beats), 32'(n));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        chk("done_pulse_drop", 32'(done_o), 32'd0);
        chk("busy_drop", 32'(busy_o), 32'd0);
        chk("done_count", 32'(done_cnt), 32'd1);
        exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = DW'(i * 3);
        rst = 1'b1;
        start_i = 1'b0;
        m_ready_i = 1'b0;
        sizeX = '0;
        sizeY = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_addr", 32'(mem_addr_o), 32'd0);
        chk("reset_data", 32'(m_data_o), 32'd0);
        chk("reset_valid", 32'(m_valid_o), 32'd0);
        chk("reset_last", 32'(m_last_o), 32'd0);
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_done", 32'(done_o), 32'd0);
        rst = 1'b0;

        run_stream(5, 10, 0);
        run_stream(5, 10, 1);
        run_stream(0, 7, 0);
        run_stream(31, 31, 0);
        run_stream(5, 10, 2);
        run_stream(5, 10, 0);
        run_stream(5, 10, 3);
        run_stream(5, 10, 0);
        run_stream(1, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
